// File: rtl/counter_reg_pkg.sv
// Shared op encoding and clr > ld > inc/dec priority decode for counter_reg.
package counter_reg_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LD   = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4
  } op_t;

  // inc and dec together cancel out to a hold.
  function automatic op_t decode_op(input logic clr, input logic ld,
                                    input logic inc, input logic dec);
    op_t op;
    op = OP_HOLD;
    if (clr)                op = OP_CLR;
    else if (ld)            op = OP_LD;
    else if (inc && !dec)   op = OP_INC;
    else if (dec && !inc)   op = OP_DEC;
    return op;
  endfunction

endpackage

// File: rtl/counter_reg_next.sv
// Combinational next-count unit: modulo wrap by default, saturation when
// COUNTER_REG_SAT_EN is defined. No state, no flow control.
module counter_reg_next
  import counter_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD   = 2**WIDTH
) (
  input  logic [WIDTH-1:0] i_out,
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_s,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_next_out,
  output logic             o_wrap_evt,
  output logic             o_range_err
);

  localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MOD - 1);

  logic [WIDTH:0] w_sum;
  logic           w_up_cross;
  logic           w_dn_cross;

  // One extra bit so out+s never aliases back into range.
  assign w_sum      = {1'b0, i_out} + {1'b0, i_s};
  assign w_up_cross = (w_sum >= LP_MOD);
  assign w_dn_cross = (i_s > i_out);

  always_comb begin
    o_next_out  = i_out;
    o_wrap_evt  = 1'b0;
    o_range_err = 1'b0;
    case (i_op)
      OP_CLR: o_next_out = '0;
      OP_LD: begin
        if ({1'b0, i_in} >= LP_MOD) begin
          o_next_out  = LP_MAX;
          o_range_err = 1'b1;
        end else begin
          o_next_out = i_in;
        end
      end
      OP_INC: begin
        if (w_up_cross) begin
          o_wrap_evt = 1'b1;
`ifdef COUNTER_REG_SAT_EN
          o_next_out = LP_MAX;
`else
          o_next_out = WIDTH'(w_sum - LP_MOD);
`endif
        end else begin
          o_next_out = WIDTH'(w_sum);
        end
      end
      OP_DEC: begin
        if (w_dn_cross) begin
          o_wrap_evt = 1'b1;
`ifdef COUNTER_REG_SAT_EN
          o_next_out = '0;
`else
          o_next_out = WIDTH'({1'b0, i_out} + LP_MOD - {1'b0, i_s});
`endif
        end else begin
          o_next_out = i_out - i_s;
        end
      end
      default: o_next_out = i_out;
    endcase
  end

endmodule

// File: rtl/counter_reg.sv
// Loadable up/down modulo counter, 1-cycle registered latency, always accepts.
// COUNTER_REG_SAT_EN selects saturating instead of wrapping inc/dec.
module counter_reg
  import counter_reg_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MOD    = 2**WIDTH,
  parameter int STEP_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ld,
  input  logic              inc,
  input  logic              dec,
  input  logic [WIDTH-1:0]  in,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  out,
  output logic              tc,
  output logic              zero,
  output logic              ovf
);

  localparam int LP_EW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;
  localparam logic [LP_EW-1:0] LP_SMAX = LP_EW'(MOD - 1);

  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic             r_zero;
  logic             r_ovf;

  op_t              w_op;
  logic [LP_EW-1:0] w_step_ext;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_next_out;
  logic             w_wrap_evt;
  logic             w_range_err;

  assign w_op       = decode_op(clr, ld, inc, dec);
  // Clamp the step so a single update can cross the modulus at most once.
  assign w_step_ext = LP_EW'(step);
  assign w_s        = (w_step_ext >= LP_SMAX) ? WIDTH'(LP_SMAX) : WIDTH'(w_step_ext);

  counter_reg_next #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .i_out       (r_out),
    .i_op        (w_op),
    .i_s         (w_s),
    .i_in        (in),
    .o_next_out  (w_next_out),
    .o_wrap_evt  (w_wrap_evt),
    .o_range_err (w_range_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_tc   <= 1'b0;
      r_zero <= 1'b1;
      r_ovf  <= 1'b0;
    end else begin
      r_out  <= w_next_out;
      r_tc   <= w_wrap_evt;
      r_zero <= (w_next_out == '0);
      r_ovf  <= (w_op == OP_CLR) ? 1'b0 : (r_ovf | w_wrap_evt | w_range_err);
    end
  end

  assign out  = r_out;
  assign tc   = r_tc;
  assign zero = r_zero;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_counter_reg.sv
// Scoreboard bench for counter_reg (WIDTH=4, MOD=10, STEP_W=2): directed
// plan cases then random traffic against an arithmetic reference model.
module tb_counter_reg;

  localparam int WIDTH  = 4;
  localparam int MOD    = 10;
  localparam int STEP_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              ld = 1'b0;
  logic              inc = 1'b1;
  logic              dec = 1'b0;
  logic [WIDTH-1:0]  in = '0;
  logic [STEP_W-1:0] step = 2'd1;
  logic [WIDTH-1:0]  out;
  logic              tc;
  logic              zero;
  logic              ovf;

  int total = 0;
  int bad   = 0;

  logic [6:0] exp_q[$];
  int         tag_q[$];

  int m_out = 0;
  bit m_ovf = 1'b0;
  int tc_seen_cont = 0;

  always #5 clk = ~clk;

  counter_reg #(
    .WIDTH  (WIDTH),
    .MOD    (MOD),
    .STEP_W (STEP_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .ld    (ld),
    .inc   (inc),
    .dec   (dec),
    .in    (in),
    .step  (step),
    .out   (out),
    .tc    (tc),
    .zero  (zero),
    .ovf   (ovf)
  );

  // Applies one cycle of controls and pushes the value the outputs must show after the edge.
  task automatic drive(input bit r, input bit c, input bit l, input bit i, input bit d,
                       input int v, input int st, input int tag);
    int s;
    int t;
    bit tcx;
    @(negedge clk);
    rst_n = r; clr = c; ld = l; inc = i; dec = d;
    in = WIDTH'(v); step = STEP_W'(st);
    tcx = 1'b0;
    if (!r) begin
      m_out = 0; m_ovf = 1'b0;
    end else if (c) begin
      m_out = 0; m_ovf = 1'b0;
    end else if (l) begin
      if (v >= MOD) begin m_out = MOD - 1; m_ovf = 1'b1; end
      else m_out = v;
    end else if (i != d) begin
      s = (st < MOD - 1) ? st : MOD - 1;
      t = i ? (m_out + s) : (m_out - s);
      if (t >= MOD || t < 0) begin
        tcx = 1'b1; m_ovf = 1'b1;
`ifdef COUNTER_REG_SAT_EN
        t = (t < 0) ? 0 : MOD - 1;
`else
        t = (t + MOD) % MOD;
`endif
      end
      m_out = t;
    end
    exp_q.push_back({WIDTH'(m_out), tcx, (m_out == 0), m_ovf});
    tag_q.push_back(tag);
  endtask

  // Monitor: compares every cycle for which stimulus queued an expectation.
  initial begin
    logic [6:0] e;
    logic [6:0] a;
    int tg;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tg = tag_q.pop_front();
        a = {out, tc, zero, ovf};
        total++;
        if (tg == 5 && tc === 1'b1) tc_seen_cont++;
        if (a !== e) begin
          bad++;
          $display("FAIL scoreboard phase=%0d: got out=%0d tc=%b zero=%b ovf=%b, want out=%0d tc=%b zero=%b ovf=%b",
                   tg, a[6:3], a[2], a[1], a[0], e[6:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    int exp_tc_cnt;
    int exp_cont_out;
`ifdef COUNTER_REG_SAT_EN
    exp_tc_cnt = 16; exp_cont_out = MOD - 1;
`else
    exp_tc_cnt = 2;  exp_cont_out = 5;
`endif
    // Reset with inc held high.
    drive(0, 0, 0, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 1, 0);
    // Load and out-of-range load.
    drive(1, 0, 1, 0, 0, 7, 0, 1);
    drive(1, 0, 1, 0, 0, 12, 0, 1);
    // Wrap up from 8 by 3, then hold to see tc drop.
    drive(1, 0, 1, 0, 0, 8, 0, 2);
    drive(1, 0, 0, 1, 0, 0, 3, 2);
    drive(1, 0, 0, 0, 0, 0, 0, 2);
    // Wrap down from 1 by 2.
    drive(1, 0, 1, 0, 0, 1, 0, 3);
    drive(1, 0, 0, 0, 1, 0, 2, 3);
    drive(1, 0, 0, 0, 0, 0, 0, 3);
    // Priority and simultaneous controls, plus step 0 and saturate-at-limit.
    drive(1, 0, 1, 0, 0, 5, 0, 4);
    drive(1, 0, 0, 1, 1, 0, 3, 4);
    drive(1, 0, 0, 1, 0, 0, 0, 4);
    drive(1, 0, 1, 1, 0, 2, 1, 4);
    drive(1, 1, 1, 0, 0, 3, 0, 4);
    drive(1, 0, 0, 0, 1, 0, 1, 4);
    drive(1, 0, 1, 0, 0, 9, 0, 4);
    drive(1, 0, 0, 1, 0, 0, 3, 4);
    drive(1, 0, 0, 1, 0, 0, 1, 4);
    // Continuous count from 0.
    drive(1, 1, 0, 0, 0, 0, 0, 4);
    for (int k = 0; k < 25; k++) drive(1, 0, 0, 1, 0, 0, 1, 5);
    @(posedge clk);
    #2;
    total++;
    if (tc_seen_cont != exp_tc_cnt) begin
      bad++;
      $display("FAIL cont_tc_count: got %0d, want %0d", tc_seen_cont, exp_tc_cnt);
    end
    total++;
    if (out !== WIDTH'(exp_cont_out)) begin
      bad++;
      $display("FAIL cont_final_out: got %0d, want %0d", out, exp_cont_out);
    end
    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(31) != 0), ($urandom_range(15) == 0), ($urandom_range(5) == 0),
            1'($urandom_range(1)), 1'($urandom_range(1)),
            int'($urandom_range(15)), int'($urandom_range(3)), 6);
    end
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
